// File: rtl/gray_to_rgb_overlay.sv
// Output stage of the lane pipeline: expands gray pixels to RGB and paints
// masked (detected-line) pixels with LINE_COLOR, tracking raster position.
//
// state   | meaning
// S_READ  | waiting for a gray byte (and mask bit); captures the pixel on pop
// S_WRITE | holding the captured pixel until the RGB FIFO accepts it
module gray_to_rgb_overlay #(
  parameter int          WIDTH      = 720,
  parameter int          HEIGHT     = 540,
  parameter logic [23:0] LINE_COLOR = 24'hFF0000,
  parameter bit          USE_MASK   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [7:0]  in_dout,
  output logic        mask_rd_en,
  input  logic        mask_empty,
  input  logic        mask_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [23:0] out_din,
  output logic        frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [23:0]   pix, pix_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          rd_ok;
  logic          pop;
  logic          push;
  logic          col_wrap;
  logic          last_pix;

  always_comb begin
    state_nx = state;
    pix_nx   = pix;
    pop      = 1'b0;
    push     = 1'b0;
    // Both FIFOs must be ready so the gray and mask streams never slip apart.
    rd_ok    = !in_empty && (!USE_MASK || !mask_empty);
    case (state)
      S_READ: begin
        if (rd_ok) begin
          pop      = 1'b1;
          pix_nx   = (USE_MASK && mask_dout) ? LINE_COLOR : {3{in_dout}};
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!out_full) begin
          push     = 1'b1;
          state_nx = S_READ;
        end
      end
      default: state_nx = S_READ;
    endcase
  end

  // Strobes are gated by reset_n so nothing is popped or pushed during reset.
  assign in_rd_en   = reset_n && pop;
  assign mask_rd_en = reset_n && pop && USE_MASK;
  assign out_wr_en  = reset_n && push;
  assign out_din    = out_wr_en ? pix : 24'h000000;

  assign col_wrap = (col == COL_LAST);
  assign last_pix = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_READ;
      pix   <= 24'h000000;
    end else begin
      state <= state_nx;
      pix   <= pix_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_wr_en && last_pix;
      if (out_wr_en) begin
        if (col_wrap) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
